// File: rtl/barrier_collide.sv
// barrier_collide: player jump FSM, collision detection, BCD score, lives and game-over latch
module barrier_collide #(
    parameter int PLAYER_COL = 7,
    parameter int AIR_TICKS  = 3,
    parameter int LIVES_INIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [7:0]  barrier,
    input  logic        jump_btn,
    output logic [1:0]  player_h,
    output logic        hit,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        game_over
);
    typedef enum logic [1:0] {GROUND, RISE, AIR, FALL} state_t;
    state_t      state, state_n;
    logic [3:0]  air_cnt, air_cnt_n;
    logic [1:0]  h_n;
    logic [15:0] score_inc;
    logic        btn_d, jump_req, rise, step, obs, coll, clr;
    assign rise = jump_btn & ~btn_d;
    assign step = tick & ~game_over;
    assign obs  = barrier[PLAYER_COL];
    assign coll = step & obs & (player_h == 2'd0);
    assign clr  = step & obs & (player_h != 2'd0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= GROUND;
            air_cnt   <= 4'd0;
            player_h  <= 2'd0;
            hit       <= 1'b0;
            score     <= 16'h0000;
            lives     <= 2'(LIVES_INIT);
            game_over <= 1'b0;
            jump_req  <= 1'b0;
            btn_d     <= 1'b0;
        end else begin
            btn_d    <= jump_btn;
            state    <= state_n;
            air_cnt  <= air_cnt_n;
            player_h <= h_n;
            hit      <= coll;
            if (!game_over)
                jump_req <= tick ? (rise & ~jump_req & (state == GROUND)) : (jump_req | rise);
            if (clr)
                score <= score_inc;
            if (coll)
                lives <= lives - 2'd1;
            game_over <= game_over | (coll & (lives == 2'd1));
        end
    end
    always_comb begin
        state_n   = state;
        air_cnt_n = air_cnt;
        if (step) begin
            case (state)
                GROUND: state_n = jump_req ? RISE : GROUND;
                RISE: begin
                    state_n   = AIR;
                    air_cnt_n = 4'(AIR_TICKS - 1);
                end
                AIR: begin
                    state_n   = air_cnt == 4'd0 ? FALL : AIR;
                    air_cnt_n = air_cnt == 4'd0 ? air_cnt : air_cnt - 4'd1;
                end
                default: state_n = GROUND;
            endcase
        end
    end
    always_comb begin
        logic c;
        h_n       = state_n == GROUND ? 2'd0 : state_n == AIR ? 2'd2 : 2'd1;
        score_inc = score;
        c         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            score_inc[4*i +: 4] = c ? (score[4*i +: 4] == 4'd9 ? 4'd0 : score[4*i +: 4] + 4'd1) : score[4*i +: 4];
            c = c & (score[4*i +: 4] == 4'd9);
        end
    end
endmodule
